// File: rtl/display_scanner.sv
// Purpose: signed binary to sign-magnitude BCD (double dabble) plus 4-digit scan multiplexer.
// Latency: display updates and done pulses WIDTH+2 cycles after the load-sampling edge; digit_num is combinational.
// Backpressure: none; load is ignored while busy, scanning never stalls.
module display_scanner #(
   parameter int WIDTH       = 10,
   parameter int REFRESH_DIV = 100000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] value_in,
   input  logic             load,
   output logic [1:0]       digit_sel,
   output logic [3:0]       digit_num,
   output logic             busy,
   output logic             done
);

   localparam int RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int ICW = 4;   // iteration counter, enough for WIDTH up to 10

   localparam logic [3:0] CODE_BLANK = 4'd14;
   localparam logic [3:0] CODE_MINUS = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_ABS, S_SHIFT, S_COMMIT} state_t;

   state_t           state_q, state_d;
   logic [RCW-1:0]   refresh_cnt;
   logic [WIDTH-1:0] val_q;
   logic             sign_q;
   logic [WIDTH-1:0] mag_q;
   logic [WIDTH-1:0] mag_abs;
   logic [11:0]      bcd_q;
   logic [11:0]      bcd_next;
   logic [ICW-1:0]   iter_q;
   logic [3:0]       disp3, disp2, disp1, disp0;
   logic [3:0]       bcd_h, bcd_t, bcd_u;

   // Refresh counter and digit select, free-running regardless of conversion activity
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_cnt <= '0;
         digit_sel   <= 2'd0;
      end else if (refresh_cnt == RCW'(REFRESH_DIV - 1)) begin
         refresh_cnt <= '0;
         digit_sel   <= digit_sel + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   // Conversion FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Conversion FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (load) state_d = S_ABS;
         S_ABS:    state_d = S_SHIFT;
         S_SHIFT:  if (iter_q == ICW'(WIDTH - 1)) state_d = S_COMMIT;
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Conversion FSM outputs
   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_COMMIT);
   end

   // Two's-complement negation; an unsigned WIDTH-bit result holds 2^(WIDTH-1) exactly,
   // so the most negative input converts without overflow.
   assign mag_abs = sign_q ? (~val_q + 1'b1) : val_q;

   // One double-dabble step. The hundreds nibble is at most 2 before the final shift
   // for any legal WIDTH, so it never needs the +3 correction.
   always_comb begin
      bcd_next[3:0]  = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
      bcd_next[7:4]  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
      bcd_next[11:8] = bcd_q[11:8];
   end

   // Conversion datapath: sample, absolute value, shift-and-add iterations
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q  <= '0;
         sign_q <= 1'b0;
         mag_q  <= '0;
         bcd_q  <= '0;
         iter_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load) begin
                  val_q  <= value_in;
                  sign_q <= value_in[WIDTH-1];
               end
            end
            S_ABS: begin
               mag_q  <= mag_abs;
               bcd_q  <= '0;
               iter_q <= '0;
            end
            S_SHIFT: begin
               bcd_q  <= {bcd_next[10:0], mag_q[WIDTH-1]};
               mag_q  <= {mag_q[WIDTH-2:0], 1'b0};
               iter_q <= iter_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bcd_h = bcd_q[11:8];
   assign bcd_t = bcd_q[7:4];
   assign bcd_u = bcd_q[3:0];

   // Display registers, all four written together so the scanner never sees a mix
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp3 <= CODE_BLANK;
         disp2 <= CODE_BLANK;
         disp1 <= CODE_BLANK;
         disp0 <= 4'd0;
      end else if (state_q == S_COMMIT) begin
         disp3 <= sign_q ? CODE_MINUS : CODE_BLANK;
         disp2 <= (bcd_h == 4'd0) ? CODE_BLANK : bcd_h;
         disp1 <= ((bcd_h == 4'd0) && (bcd_t == 4'd0)) ? CODE_BLANK : bcd_t;
         disp0 <= bcd_u;
      end
   end

   // Select the committed code for the currently scanned digit
   always_comb begin
      digit_num = disp0;
      case (digit_sel)
         2'd0: digit_num = disp0;
         2'd1: digit_num = disp1;
         2'd2: digit_num = disp2;
         2'd3: digit_num = disp3;
         default: digit_num = disp0;
      endcase
   end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: directed cases plus random signed values against a decimal reference model.
// Digits are observed by watching the scan run through all four selects.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_display_scanner;

   localparam int W  = 10;
   localparam int RD = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] value_in = '0;
   logic [1:0]   digit_sel;
   logic [3:0]   digit_num;
   logic         busy;
   logic         done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   display_scanner #(.WIDTH(W), .REFRESH_DIV(RD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .value_in  (value_in),
      .load      (load),
      .digit_sel (digit_sel),
      .digit_num (digit_num),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits of the signed value with sign and leading-zero rules
   function automatic int ref_digit(input int v, input int idx);
      int mag, h, t, u;
      mag = (v < 0) ? -v : v;
      h = mag / 100;
      t = (mag / 10) % 10;
      u = mag % 10;
      case (idx)
         3: return (v < 0) ? 15 : 14;
         2: return (h == 0) ? 14 : h;
         1: return (h == 0 && t == 0) ? 14 : t;
         default: return u;
      endcase
   endfunction

   // Watch a full scan round and compare what each digit position shows
   task automatic check_display(input int v, input string tag);
      int seen [4];
      bit got [4];
      for (int i = 0; i < 4; i++) begin
         seen[i] = 0;
         got[i]  = 1'b0;
      end
      repeat (4 * RD) begin
         @(negedge clk);
         seen[digit_sel] = digit_num;
         got[digit_sel]  = 1'b1;
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s digit%0d", tag, i), got[i] ? seen[i] : -1, ref_digit(v, i));
   endtask

   // Call on a falling edge. Returns on the falling edge of the first idle cycle.
   // A second load of ign_v is pulsed at busy-cycle index ign_at (negative: never).
   task automatic do_load(input int v, input int ign_at, input int ign_v, input string tag);
      int bc, dc, i;
      bc = 0;
      dc = 0;
      i  = 0;
      value_in = W'(v);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      while (busy && i < 40) begin
         bc++;
         if (done) dc++;
         if (i == ign_at) begin
            value_in = W'(ign_v);
            load = 1'b1;
         end
         @(negedge clk);
         load = 1'b0;
         i++;
      end
      chk({tag, " busy_cycles"}, bc, W + 2);
      chk({tag, " done_pulses"}, dc, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int v, dc;

      // Reset mid-scan and scan pattern afterwards
      #23 rst_n = 1'b1;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #2;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst sel", digit_sel, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 16; j++) begin
         chk($sformatf("scan sel j%0d", j), digit_sel, (j / RD) % 4);
         chk($sformatf("scan num j%0d", j), digit_num, (j / RD == 0) ? 0 : 14);
         @(negedge clk);
      end

      // Directed values including both extremes
      do_load(305, -1, 0, "p305");   check_display(305, "p305");
      do_load(-7, -1, 0, "m7");      check_display(-7, "m7");
      do_load(0, -1, 0, "zero");     check_display(0, "zero");
      do_load(-512, -1, 0, "m512");  check_display(-512, "m512");
      do_load(511, -1, 0, "p511");   check_display(511, "p511");

      // Load while busy is ignored, including during the commit cycle
      do_load(123, 4, 456, "ign");   check_display(123, "ign");
      do_load(77, 11, 300, "ignc");  check_display(77, "ignc");
      do_load(456, -1, 0, "p456");   check_display(456, "p456");

      // Back-to-back: second load in the first idle cycle
      do_load(-45, -1, 0, "b2b1");
      do_load(250, -1, 0, "b2b2");
      check_display(250, "b2b2");

      // Reset in the middle of a conversion
      value_in = W'(100);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      dc = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) dc++;
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (done) dc++;
         @(negedge clk);
      end
      chk("abort no_done", dc, 0);
      check_display(0, "abort");
      do_load(100, -1, 0, "p100");   check_display(100, "p100");

      // Random signed values over the full input range
      repeat (12) begin
         v = int'($urandom_range(0, 1023)) - 512;
         do_load(v, -1, 0, $sformatf("rnd%0d", v));
         check_display(v, $sformatf("rnd%0d", v));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
